// File: rtl/micro_pkg.sv
// Shared width defines, FSM/condition enums, microword layout and NOP constants
// used by the micro-sequencer and its microcode ROM.
`ifndef MICRO_DEFINES_VH
`define MICRO_DEFINES_VH
`define WORD_SIZE 8
`define MEM_MICRO_INSTRUCTION_SIZE 3
`define ALU_MICRO_INSTRUCTION_SIZE 4
`define REG_MICRO_INSTRUCTION_SIZE 3
`endif

package micro_pkg;

    localparam int WORD_W = `WORD_SIZE;
    localparam int MEM_W  = `MEM_MICRO_INSTRUCTION_SIZE;
    localparam int ALU_W  = `ALU_MICRO_INSTRUCTION_SIZE;
    localparam int REG_W  = `REG_MICRO_INSTRUCTION_SIZE;

    localparam int OP_SEQ3  = 1;
    localparam int OP_CONDZ = 2;
    localparam int OP_HLT   = 3;
    localparam int OP_LONG  = 4;
    localparam int OP_FLAGS = 5;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        COND_NONE     = 2'd0,
        COND_IF_ZERO  = 2'd1,
        COND_IF_CARRY = 2'd2,
        COND_IF_NZERO = 2'd3
    } cond_t;

    typedef struct packed {
        logic [MEM_W-1:0] mem_op;
        logic [ALU_W-1:0] alu_op;
        logic [REG_W-1:0] reg_op;
        cond_t            cond;
        logic             last;
        logic             hlt;
    } microword_t;

    localparam logic [MEM_W-1:0] MEM_NOP = '0;
    localparam logic [ALU_W-1:0] ALU_NOP = '0;
    localparam logic [REG_W-1:0] REG_NOP = '0;

    // Unmapped ROM entries behave as a single do-nothing step.
    localparam microword_t MICRO_NOP = '{
        mem_op: MEM_NOP,
        alu_op: ALU_NOP,
        reg_op: REG_NOP,
        cond:   COND_NONE,
        last:   1'b1,
        hlt:    1'b0
    };

    function automatic microword_t mw(input int mem, input int alu, input int rg,
                                      input cond_t c, input logic last, input logic hlt);
        microword_t w;
        w.mem_op = MEM_W'(mem);
        w.alu_op = ALU_W'(alu);
        w.reg_op = REG_W'(rg);
        w.cond   = c;
        w.last   = last;
        w.hlt    = hlt;
        return w;
    endfunction

    function automatic logic cond_true(input cond_t c, input logic zero, input logic carry);
        logic ok;
        case (c)
            COND_IF_ZERO:  ok = zero;
            COND_IF_CARRY: ok = carry;
            COND_IF_NZERO: ok = ~zero;
            default:       ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode store indexed by {opcode, step}; anything not listed
// is a single NOP step that completes the instruction.
module microcode_rom
    import micro_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int STEP_W   = 2
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [STEP_W-1:0]   step,
    output microword_t          word
);

    always_comb begin
        word = MICRO_NOP;
        case (int'(opcode))
            OP_SEQ3: begin
                case (int'(step))
                    0:       word = mw(1, 0, 0, COND_NONE, 1'b0, 1'b0);
                    1:       word = mw(0, 2, 1, COND_NONE, 1'b0, 1'b0);
                    2:       word = mw(0, 0, 2, COND_NONE, 1'b1, 1'b0);
                    default: word = MICRO_NOP;
                endcase
            end
            OP_CONDZ: word = mw(2, 3, 3, COND_IF_ZERO, 1'b1, 1'b0);
            OP_HLT:   word = mw(0, 1, 0, COND_NONE, 1'b1, 1'b1);
            // No last bit anywhere: the step limit is what ends this one.
            OP_LONG: begin
                case (int'(step))
                    0:       word = mw(0, 4, 0, COND_NONE, 1'b0, 1'b0);
                    1:       word = mw(0, 5, 0, COND_NONE, 1'b0, 1'b0);
                    2:       word = mw(0, 6, 0, COND_NONE, 1'b0, 1'b0);
                    3:       word = mw(0, 7, 0, COND_NONE, 1'b0, 1'b0);
                    default: word = MICRO_NOP;
                endcase
            end
            OP_FLAGS: begin
                case (int'(step))
                    0:       word = mw(5, 0, 0, COND_IF_CARRY, 1'b0, 1'b0);
                    1:       word = mw(0, 0, 5, COND_IF_NZERO, 1'b1, 1'b0);
                    default: word = MICRO_NOP;
                endcase
            end
            default: word = MICRO_NOP;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// FETCH/EXEC/HALT micro-sequencer: latches an opcode, walks its microprogram one
// step per cycle and gates the micro fields, PC hold and memory clock enable.
module micro_sequencer
    import micro_pkg::*;
#(
    parameter int MAX_STEPS = 4,
    parameter int OPCODE_W  = 4,
    localparam int STEP_W   = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] instruction_code,
    input  logic              zero_flag,
    input  logic              carry_flag,
    input  logic              ext_halt,
    input  logic              resume,
    output logic [MEM_W-1:0]  mem_instruction,
    output logic [ALU_W-1:0]  alu_instruction,
    output logic [REG_W-1:0]  reg_instruction,
    output logic              ce,
    output logic              halt_pc,
    output logic              halted,
    output logic [STEP_W-1:0] step
);

    state_t              state, state_next;
    logic [STEP_W-1:0]   step_q, step_next;
    logic [OPCODE_W-1:0] ir_op, ir_next;
    microword_t          word;
    logic                complete;

    generate
        if (OPCODE_W < WORD_W) begin : g_unused
            logic unused_code_bits;
            assign unused_code_bits = ^instruction_code[WORD_W-1:OPCODE_W];
        end
    endgenerate

    microcode_rom #(
        .OPCODE_W (OPCODE_W),
        .STEP_W   (STEP_W)
    ) u_rom (
        .opcode (ir_op),
        .step   (step_q),
        .word   (word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= FETCH;
            step_q <= '0;
            ir_op  <= '0;
        end else begin
            state  <= state_next;
            step_q <= step_next;
            ir_op  <= ir_next;
        end
    end

    assign step     = step_q;
    assign complete = word.last || (step_q == STEP_W'(MAX_STEPS - 1));

    always_comb begin
        state_next      = state;
        step_next       = step_q;
        ir_next         = ir_op;
        mem_instruction = MEM_NOP;
        alu_instruction = ALU_NOP;
        reg_instruction = REG_NOP;
        ce              = 1'b0;
        halt_pc         = 1'b1;
        halted          = 1'b0;

        case (state)
            FETCH: begin
                ce         = 1'b1;
                ir_next    = instruction_code[OPCODE_W-1:0];
                step_next  = '0;
                state_next = EXEC;
            end
            EXEC: begin
                ce = 1'b1;
                if (cond_true(word.cond, zero_flag, carry_flag)) begin
                    mem_instruction = word.mem_op;
                    alu_instruction = word.alu_op;
                    reg_instruction = word.reg_op;
                end
                // Only the completing step lets the PC move.
                if (complete) begin
                    halt_pc    = 1'b0;
                    step_next  = '0;
                    state_next = (word.hlt || ext_halt) ? HALT : FETCH;
                end else begin
                    step_next = step_q + STEP_W'(1);
                end
            end
            HALT: begin
                halted = 1'b1;
                if (resume && !ext_halt) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase

        // Reset masks the FETCH decode so nothing is enabled while it is held.
        if (reset) begin
            mem_instruction = MEM_NOP;
            alu_instruction = ALU_NOP;
            reg_instruction = REG_NOP;
            ce              = 1'b0;
            halt_pc         = 1'b1;
            halted          = 1'b0;
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: per-cycle vector tables with hand-derived
// expected outputs for each scenario.
module tb_micro_sequencer;

    localparam int WORD_W = micro_pkg::WORD_W;
    localparam int MEM_W  = micro_pkg::MEM_W;
    localparam int ALU_W  = micro_pkg::ALU_W;
    localparam int REG_W  = micro_pkg::REG_W;

    typedef struct packed {
        logic [MEM_W-1:0] mem;
        logic [ALU_W-1:0] alu;
        logic [REG_W-1:0] rg;
        logic [1:0]       step;
        logic             ce;
        logic             halt_pc;
        logic             halted;
    } obs_t;

    typedef struct packed {
        logic [WORD_W-1:0] code;
        logic              zf;
        logic              cf;
        logic              eh;
        logic              res;
        obs_t              exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [WORD_W-1:0] instruction_code;
    logic              zero_flag, carry_flag, ext_halt, resume;
    logic [MEM_W-1:0]  mem_instruction;
    logic [ALU_W-1:0]  alu_instruction;
    logic [REG_W-1:0]  reg_instruction;
    logic              ce, halt_pc, halted;
    logic [1:0]        step;

    int errors = 0;
    int checks = 0;

    micro_sequencer #(
        .MAX_STEPS (4),
        .OPCODE_W  (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .instruction_code (instruction_code),
        .zero_flag        (zero_flag),
        .carry_flag       (carry_flag),
        .ext_halt         (ext_halt),
        .resume           (resume),
        .mem_instruction  (mem_instruction),
        .alu_instruction  (alu_instruction),
        .reg_instruction  (reg_instruction),
        .ce               (ce),
        .halt_pc          (halt_pc),
        .halted           (halted),
        .step             (step)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        return {mem_instruction, alu_instruction, reg_instruction, step, ce, halt_pc, halted};
    endfunction

    function automatic obs_t e(input int mem, input int alu, input int rg, input int st,
                               input bit c, input bit hpc, input bit hlt);
        obs_t o;
        o.mem     = MEM_W'(mem);
        o.alu     = ALU_W'(alu);
        o.rg      = REG_W'(rg);
        o.step    = 2'(st);
        o.ce      = c;
        o.halt_pc = hpc;
        o.halted  = hlt;
        return o;
    endfunction

    function automatic vec_t row(input int code, input bit zf, input bit cf, input bit eh,
                                 input bit res, input obs_t exp);
        vec_t v;
        v.code = WORD_W'(code);
        v.zf   = zf;
        v.cf   = cf;
        v.eh   = eh;
        v.res  = res;
        v.exp  = exp;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t o;
        reset = 1'b1;
        instruction_code = '0;
        zero_flag = 1'b0; carry_flag = 1'b0; ext_halt = 1'b0; resume = 1'b0;
        tick();
        tick();
        o = sample();
        checks++;
        if (o !== e(0, 0, 0, 0, 0, 1, 0)) begin
            errors++;
            $display("[TB] FAIL reset_held got=%h want=%h", o, e(0, 0, 0, 0, 0, 1, 0));
        end
        reset = 1'b0;
        #1;
        o = sample();
        checks++;
        if (o !== e(0, 0, 0, 0, 1, 1, 0)) begin
            errors++;
            $display("[TB] FAIL reset_first_fetch got=%h want=%h", o, e(0, 0, 0, 0, 1, 1, 0));
        end
    endtask

    task automatic test_seq3();
        vec_t v[$];
        v.push_back(row(1, 0, 0, 0, 0, e(0, 0, 0, 0, 1, 1, 0)));
        v.push_back(row(1, 0, 0, 0, 0, e(1, 0, 0, 0, 1, 1, 0)));
        v.push_back(row(1, 0, 0, 0, 0, e(0, 2, 1, 1, 1, 1, 0)));
        v.push_back(row(1, 0, 0, 0, 0, e(0, 0, 2, 2, 1, 0, 0)));
        foreach (v[i]) begin
            instruction_code = v[i].code; zero_flag = v[i].zf; carry_flag = v[i].cf;
            ext_halt = v[i].eh; resume = v[i].res;
            #1;
            checks++;
            if (sample() !== v[i].exp) begin
                errors++;
                $display("[TB] FAIL seq3[%0d] got=%h want=%h", i, sample(), v[i].exp);
            end
            tick();
        end
    endtask

    task automatic test_conditional();
        vec_t v[$];
        v.push_back(row(2, 0, 0, 0, 0, e(0, 0, 0, 0, 1, 1, 0)));
        v.push_back(row(2, 0, 0, 0, 0, e(0, 0, 0, 0, 1, 0, 0)));
        v.push_back(row(2, 0, 0, 0, 0, e(0, 0, 0, 0, 1, 1, 0)));
        v.push_back(row(2, 1, 0, 0, 0, e(2, 3, 3, 0, 1, 0, 0)));
        v.push_back(row(5, 0, 0, 0, 0, e(0, 0, 0, 0, 1, 1, 0)));
        v.push_back(row(5, 0, 0, 0, 0, e(0, 0, 0, 0, 1, 1, 0)));
        v.push_back(row(5, 0, 0, 0, 0, e(0, 0, 5, 1, 1, 0, 0)));
        v.push_back(row(5, 0, 0, 0, 0, e(0, 0, 0, 0, 1, 1, 0)));
        v.push_back(row(5, 0, 1, 0, 0, e(5, 0, 0, 0, 1, 1, 0)));
        v.push_back(row(5, 1, 0, 0, 0, e(0, 0, 0, 1, 1, 0, 0)));
        foreach (v[i]) begin
            instruction_code = v[i].code; zero_flag = v[i].zf; carry_flag = v[i].cf;
            ext_halt = v[i].eh; resume = v[i].res;
            #1;
            checks++;
            if (sample() !== v[i].exp) begin
                errors++;
                $display("[TB] FAIL cond[%0d] got=%h want=%h", i, sample(), v[i].exp);
            end
            tick();
        end
    endtask

    task automatic test_ext_halt();
        vec_t v[$];
        v.push_back(row(1, 0, 0, 0, 0, e(0, 0, 0, 0, 1, 1, 0)));
        v.push_back(row(1, 0, 0, 0, 0, e(1, 0, 0, 0, 1, 1, 0)));
        v.push_back(row(1, 0, 0, 1, 0, e(0, 2, 1, 1, 1, 1, 0)));
        v.push_back(row(1, 0, 0, 1, 0, e(0, 0, 2, 2, 1, 0, 0)));
        v.push_back(row(1, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 1, 1)));
        v.push_back(row(1, 0, 0, 0, 1, e(0, 0, 0, 0, 0, 1, 1)));
        v.push_back(row(1, 0, 0, 0, 1, e(0, 0, 0, 0, 1, 1, 0)));
        v.push_back(row(1, 0, 0, 1, 1, e(1, 0, 0, 0, 1, 1, 0)));
        v.push_back(row(1, 0, 0, 0, 1, e(0, 2, 1, 1, 1, 1, 0)));
        v.push_back(row(1, 0, 0, 0, 1, e(0, 0, 2, 2, 1, 0, 0)));
        foreach (v[i]) begin
            instruction_code = v[i].code; zero_flag = v[i].zf; carry_flag = v[i].cf;
            ext_halt = v[i].eh; resume = v[i].res;
            #1;
            checks++;
            if (sample() !== v[i].exp) begin
                errors++;
                $display("[TB] FAIL ext_halt[%0d] got=%h want=%h", i, sample(), v[i].exp);
            end
            tick();
        end
    endtask

    task automatic test_hlt_opcode();
        vec_t v[$];
        v.push_back(row(3, 0, 0, 0, 0, e(0, 0, 0, 0, 1, 1, 0)));
        v.push_back(row(3, 0, 0, 0, 0, e(0, 1, 0, 0, 1, 0, 0)));
        v.push_back(row(3, 0, 0, 1, 1, e(0, 0, 0, 0, 0, 1, 1)));
        v.push_back(row(3, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 1, 1)));
        v.push_back(row(3, 0, 0, 0, 1, e(0, 0, 0, 0, 0, 1, 1)));
        foreach (v[i]) begin
            instruction_code = v[i].code; zero_flag = v[i].zf; carry_flag = v[i].cf;
            ext_halt = v[i].eh; resume = v[i].res;
            #1;
            checks++;
            if (sample() !== v[i].exp) begin
                errors++;
                $display("[TB] FAIL hlt_op[%0d] got=%h want=%h", i, sample(), v[i].exp);
            end
            tick();
        end
    endtask

    task automatic test_max_steps();
        vec_t v[$];
        v.push_back(row(4, 0, 0, 0, 0, e(0, 0, 0, 0, 1, 1, 0)));
        v.push_back(row(4, 0, 0, 0, 0, e(0, 4, 0, 0, 1, 1, 0)));
        v.push_back(row(4, 0, 0, 0, 0, e(0, 5, 0, 1, 1, 1, 0)));
        v.push_back(row(4, 0, 0, 0, 0, e(0, 6, 0, 2, 1, 1, 0)));
        v.push_back(row(4, 0, 0, 0, 0, e(0, 7, 0, 3, 1, 0, 0)));
        foreach (v[i]) begin
            instruction_code = v[i].code; zero_flag = v[i].zf; carry_flag = v[i].cf;
            ext_halt = v[i].eh; resume = v[i].res;
            #1;
            checks++;
            if (sample() !== v[i].exp) begin
                errors++;
                $display("[TB] FAIL max_steps[%0d] got=%h want=%h", i, sample(), v[i].exp);
            end
            tick();
        end
    endtask

    task automatic test_unmapped();
        vec_t v[$];
        v.push_back(row(9, 0, 0, 0, 0, e(0, 0, 0, 0, 1, 1, 0)));
        v.push_back(row(9, 0, 0, 0, 0, e(0, 0, 0, 0, 1, 0, 0)));
        v.push_back(row(1, 0, 0, 0, 0, e(0, 0, 0, 0, 1, 1, 0)));
        foreach (v[i]) begin
            instruction_code = v[i].code; zero_flag = v[i].zf; carry_flag = v[i].cf;
            ext_halt = v[i].eh; resume = v[i].res;
            #1;
            checks++;
            if (sample() !== v[i].exp) begin
                errors++;
                $display("[TB] FAIL unmapped[%0d] got=%h want=%h", i, sample(), v[i].exp);
            end
            tick();
        end
    endtask

    // Entered with opcode 1 already fetched, so the first cycle here is EXEC s0.
    task automatic test_reset_mid();
        vec_t v[$];
        v.push_back(row(1, 0, 0, 0, 0, e(1, 0, 0, 0, 1, 1, 0)));
        v.push_back(row(1, 0, 0, 0, 0, e(0, 2, 1, 1, 1, 1, 0)));
        v.push_back(row(1, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 1, 0)));
        v.push_back(row(1, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 1, 0)));
        v.push_back(row(1, 0, 0, 0, 0, e(0, 0, 0, 0, 1, 1, 0)));
        v.push_back(row(1, 0, 0, 0, 0, e(1, 0, 0, 0, 1, 1, 0)));
        foreach (v[i]) begin
            instruction_code = v[i].code; zero_flag = v[i].zf; carry_flag = v[i].cf;
            ext_halt = v[i].eh; resume = v[i].res;
            if (i == 2) reset = 1'b1;
            if (i == 4) reset = 1'b0;
            #1;
            checks++;
            if (sample() !== v[i].exp) begin
                errors++;
                $display("[TB] FAIL reset_mid[%0d] got=%h want=%h", i, sample(), v[i].exp);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_seq3();
        test_conditional();
        test_ext_halt();
        test_hlt_opcode();
        test_max_steps();
        test_unmapped();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
